yutorina_ctrl_unit: RTL and testbench
=====================================

Name: yutorina_ctrl_unit

Overview:
- Pipeline control unit for the 4-stage Yutorina core (IF/ID/EX/MEM).
- Generates per-stage stall/flush signals and the redirect PC.
- Owns the special-purpose register file (STATUS, PRE_STATUS, EPC, EXP_VECTOR, EXP_CODE), supplying `mode` and `spr_r_data` to the ID stage.
- Commits exceptions, interrupts, EXRT, WSR and HALT at the MEM boundary.

Parameters:
- ADDR_W, 30, word-address width (PC, EPC, vector).
- DATA_W, 32, SPR data width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- if_busy  in  1  IF bus access pending
- mem_busy  in  1  MEM bus access pending
- ld_haz  in  1  load-use hazard from ID
- br_taken  in  1  branch resolved taken in ID
- br_addr  in  ADDR_W  branch target
- irq  in  1  external interrupt request, level
- mem_en_  in  1  MEM-stage instruction valid, active-low
- mem_pc  in  ADDR_W  PC of MEM-stage instruction
- mem_exp_code  in  3  exception code of MEM instruction
- mem_ctrl_op  in  2  NONE=0, WSR=1, EXRT=2, HALT=3
- mem_spr_addr  in  3  WSR target SPR
- mem_out  in  DATA_W  WSR data
- spr_r_addr  in  3  SPR read address from ID
- spr_r_data  out  DATA_W  combinational SPR read
- mode  out  1  0=kernel, 1=user
- if_stall, id_stall, ex_stall, mem_stall  out  1 each
- if_flush, id_flush, ex_flush, mem_flush  out  1 each
- new_pc  out  ADDR_W  redirect target, valid when if_flush=1

Behaviour:
- Reset:
  - STATUS={int_en=0, mode=0}; PRE_STATUS=0; EPC=0; EXP_VECTOR=0; EXP_CODE=0; state=RUN.
  - All stall/flush outputs 0; new_pc=0.
- SPR map: 0 STATUS {bit1 int_en, bit0 mode}; 1 PRE_STATUS; 2 EPC; 3 EXP_VECTOR; 4 EXP_CODE; 5–7 read 0.
- spr_r_data is a combinational read with no bypass: a same-cycle WSR is visible the next cycle.
- Stall/flush outputs and new_pc are combinational. SPR and state updates occur on posedge clk.
- Priority, highest first:
  1. busy: if_busy|mem_busy → all four stalls=1, all flushes=0. No SPR or state update.
  2. exception: mem_en_=0 and mem_exp_code≠0, or interrupt taken → all flushes=1, new_pc=EXP_VECTOR.
     - Next edge: EPC←mem_pc; EXP_CODE←code; PRE_STATUS←STATUS; STATUS←{0,0}.
     - An interrupt uses code 1 with EPC=mem_pc.
  3. EXRT: mem_en_=0, ctrl_op=2 → all flushes=1, new_pc=EPC; STATUS←PRE_STATUS.
  4. WSR: mem_en_=0, ctrl_op=1 → SPR[mem_spr_addr]←mem_out; all flushes=1, new_pc=mem_pc+1 (refetch under new mode). Writes to addresses 5–7 are ignored.
  5. HALT: mem_en_=0, ctrl_op=3 → flush IF/ID/EX; state←HALT; halt_pc←mem_pc+1.
  6. br_taken → if_flush=1, new_pc=br_addr.
  7. ld_haz → if_stall=1, id_flush=1 (bubble).
  - br_taken and ld_haz together: the branch wins.
- Interrupt taken: irq=1, int_en=1, state=RUN, not busy.
- Exception codes: 0 NONE, 1 EXT_INT, 2 UNDEF, 3 OVERFLOW, 4 MISS_ALIGN, 5 TRAP, 6 PRV_VIO.
- State machine RUN/HALT:
  - HALT → all stalls=1.
  - irq & int_en → take interrupt with EPC=halt_pc; flush all; state←RUN.
  - irq without int_en → remain in HALT (no wake).
- mode output equals STATUS bit 0.
- Wrap-around: mem_pc+1 wraps modulo 2^ADDR_W.
- Reset mid-stall or in HALT: returns to the reset state immediately.

Optional Feature:
- Macro: YUTORINA_CYCLE_CNT_EN.
- Defined:
  - SPR 5 is a DATA_W free-running cycle counter, reset 0, incrementing every cycle including stalls.
  - It wraps from all-ones to 0.
  - WSR to 5 loads mem_out; the counter resumes incrementing the next cycle.
- Undefined: SPR 5 reads 0 and writes are ignored.

Decomposition:
- spr.h / shared package: SPR addresses, STATUS bit positions, mode encodings.
- exp.h: exception codes.
- isa.h: CTRL_* encodings.
- One natural sub-module: yutorina_spr_file (registers, read mux, write port, cycle counter). Priority logic and the FSM stay in the top module.

Test Plan:
- if_busy=1 with br_taken=1 → all stalls=1, if_flush=0. Drop busy next cycle with branch still asserted → if_flush=1, new_pc=br_addr.
- MEM UNDEF at mem_pc=0x100, EXP_VECTOR=0x40, STATUS={1,1} → flushes=1, new_pc=0x40. Next cycle: EPC=0x100, EXP_CODE=2, STATUS=0, PRE_STATUS=3.
- Follow with EXRT → new_pc=0x100, STATUS=3, mode=1.
- WSR STATUS←1 at mem_pc=0x20 → flushes=1, new_pc=0x21. Next cycle mode=1, spr_r_data(0)=1.
- HALT at 0x30 with int_en=1, then irq after 5 cycles → stalls=1 during HALT. Then flush, new_pc=EXP_VECTOR, EPC=0x31, EXP_CODE=1.
- ld_haz=1 → if_stall=1, id_flush=1. With YUTORINA_CYCLE_CNT_EN, after reset + 10 cycles SPR5 reads 10.

Source files
------------

// File: rtl/yutorina_ctrl_unit_pkg.sv
// Shared definitions for the Yutorina pipeline control unit:
// SPR addresses, STATUS bit positions, mode encodings, exception codes,
// MEM-stage control-op encodings and the RUN/HALT state type.
package yutorina_ctrl_unit_pkg;

  // Special-purpose register addresses
  localparam logic [2:0] SPR_STATUS     = 3'd0;
  localparam logic [2:0] SPR_PRE_STATUS = 3'd1;
  localparam logic [2:0] SPR_EPC        = 3'd2;
  localparam logic [2:0] SPR_EXP_VECTOR = 3'd3;
  localparam logic [2:0] SPR_EXP_CODE   = 3'd4;
  localparam logic [2:0] SPR_CYCLE_CNT  = 3'd5;

  // STATUS bit positions
  localparam int STATUS_MODE_BIT   = 0;
  localparam int STATUS_INT_EN_BIT = 1;

  // Processor mode encodings (STATUS bit 0)
  localparam logic MODE_KERNEL = 1'b0;
  localparam logic MODE_USER   = 1'b1;

  // Exception codes
  localparam logic [2:0] EXP_NONE       = 3'd0;
  localparam logic [2:0] EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] EXP_UNDEF      = 3'd2;
  localparam logic [2:0] EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] EXP_TRAP       = 3'd5;
  localparam logic [2:0] EXP_PRV_VIO    = 3'd6;

  // MEM-stage control operations
  localparam logic [1:0] CTRL_NONE = 2'd0;
  localparam logic [1:0] CTRL_WSR  = 2'd1;
  localparam logic [1:0] CTRL_EXRT = 2'd2;
  localparam logic [1:0] CTRL_HALT = 2'd3;

  // Control unit run state
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/yutorina_ctrl_unit_spr.sv
// Special-purpose register file for the Yutorina control unit.
// Holds STATUS, PRE_STATUS, EPC, EXP_VECTOR and EXP_CODE; an exception commit
// takes precedence over EXRT, which takes precedence over a WSR write.
// Optional macro YUTORINA_CYCLE_CNT_EN adds a free-running cycle counter at SPR 5.
module yutorina_spr_file
  import yutorina_ctrl_unit_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wrEn,
  input  logic [2:0]        i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_expTake,
  input  logic [ADDR_W-1:0] i_expPc,
  input  logic [2:0]        i_expCode,
  input  logic              i_exrt,
  input  logic [2:0]        i_rdAddr,
  output logic [DATA_W-1:0] o_rdData,
  output logic [1:0]        o_status,
  output logic [ADDR_W-1:0] o_epc,
  output logic [ADDR_W-1:0] o_expVector
);

  logic [1:0]        r_status;
  logic [1:0]        r_preStatus;
  logic [ADDR_W-1:0] r_epc;
  logic [ADDR_W-1:0] r_expVector;
  logic [2:0]        r_expCode;

  // Architectural SPR updates: exception entry, exception return, then WSR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status    <= 2'b00;
      r_preStatus <= 2'b00;
      r_epc       <= '0;
      r_expVector <= '0;
      r_expCode   <= EXP_NONE;
    end else if (i_expTake) begin
      r_epc       <= i_expPc;
      r_expCode   <= i_expCode;
      r_preStatus <= r_status;
      r_status    <= 2'b00;
    end else if (i_exrt) begin
      r_status    <= r_preStatus;
    end else if (i_wrEn) begin
      case (i_wrAddr)
        SPR_STATUS:     r_status    <= i_wrData[1:0];
        SPR_PRE_STATUS: r_preStatus <= i_wrData[1:0];
        SPR_EPC:        r_epc       <= i_wrData[ADDR_W-1:0];
        SPR_EXP_VECTOR: r_expVector <= i_wrData[ADDR_W-1:0];
        SPR_EXP_CODE:   r_expCode   <= i_wrData[2:0];
        default:        ;
      endcase
    end
  end

`ifdef YUTORINA_CYCLE_CNT_EN
  logic [DATA_W-1:0] r_cycleCnt;

  // Free-running cycle counter; a WSR loads it and counting resumes next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycleCnt <= '0;
    end else if (i_wrEn && (i_wrAddr == SPR_CYCLE_CNT)) begin
      r_cycleCnt <= i_wrData;
    end else begin
      r_cycleCnt <= r_cycleCnt + DATA_W'(1);
    end
  end
`else
  logic w_unusedWrHigh;
  assign w_unusedWrHigh = ^i_wrData[DATA_W-1:ADDR_W];
`endif

  // Combinational read port with no write bypass
  always_comb begin
    o_rdData = '0;
    case (i_rdAddr)
      SPR_STATUS:     o_rdData = DATA_W'(r_status);
      SPR_PRE_STATUS: o_rdData = DATA_W'(r_preStatus);
      SPR_EPC:        o_rdData = DATA_W'(r_epc);
      SPR_EXP_VECTOR: o_rdData = DATA_W'(r_expVector);
      SPR_EXP_CODE:   o_rdData = DATA_W'(r_expCode);
`ifdef YUTORINA_CYCLE_CNT_EN
      SPR_CYCLE_CNT:  o_rdData = r_cycleCnt;
`endif
      default:        o_rdData = '0;
    endcase
  end

  assign o_status    = r_status;
  assign o_epc       = r_epc;
  assign o_expVector = r_expVector;

endmodule

// File: rtl/yutorina_ctrl_unit.sv
// Pipeline control unit for the 4-stage Yutorina core (IF/ID/EX/MEM).
// Resolves stall/flush priority, produces the redirect PC, commits
// exceptions/interrupts/EXRT/WSR/HALT at the MEM boundary and runs the
// RUN/HALT state machine. Optional macro YUTORINA_CYCLE_CNT_EN enables the
// SPR 5 cycle counter inside yutorina_spr_file.
module yutorina_ctrl_unit
  import yutorina_ctrl_unit_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_haz,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              irq,
  input  logic              mem_en_,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [2:0]        mem_exp_code,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [2:0]        mem_spr_addr,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [2:0]        spr_r_addr,
  output logic [DATA_W-1:0] spr_r_data,
  output logic              mode,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc
);

  ctrl_state_t       r_state;
  logic [ADDR_W-1:0] r_haltPc;

  logic [1:0]        w_status;
  logic [ADDR_W-1:0] w_epc;
  logic [ADDR_W-1:0] w_expVector;
  logic              w_busy;
  logic              w_memValid;
  logic              w_memExp;
  logic              w_intReq;
  logic [ADDR_W-1:0] w_nextPc;
  logic              w_expTake;
  logic [ADDR_W-1:0] w_expPc;
  logic [2:0]        w_expCode;
  logic              w_exrt;
  logic              w_wrEn;
  logic              w_haltEnter;
  logic              w_wake;

  assign w_busy     = if_busy | mem_busy;
  assign w_memValid = ~mem_en_;
  assign w_memExp   = w_memValid && (mem_exp_code != EXP_NONE);
  assign w_intReq   = irq && w_status[STATUS_INT_EN_BIT];
  assign w_nextPc   = mem_pc + ADDR_W'(1);
  assign mode       = w_status[STATUS_MODE_BIT];

  yutorina_spr_file #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_spr (
    .clk         (clk),
    .rst         (rst),
    .i_wrEn      (w_wrEn),
    .i_wrAddr    (mem_spr_addr),
    .i_wrData    (mem_out),
    .i_expTake   (w_expTake),
    .i_expPc     (w_expPc),
    .i_expCode   (w_expCode),
    .i_exrt      (w_exrt),
    .i_rdAddr    (spr_r_addr),
    .o_rdData    (spr_r_data),
    .o_status    (w_status),
    .o_epc       (w_epc),
    .o_expVector (w_expVector)
  );

  // Priority resolution: busy, halt/wake, exception or interrupt, EXRT, WSR, HALT, branch, load-use
  always_comb begin
    {if_stall, id_stall, ex_stall, mem_stall} = 4'b0000;
    {if_flush, id_flush, ex_flush, mem_flush} = 4'b0000;
    new_pc      = '0;
    w_expTake   = 1'b0;
    w_expPc     = mem_pc;
    w_expCode   = mem_exp_code;
    w_exrt      = 1'b0;
    w_wrEn      = 1'b0;
    w_haltEnter = 1'b0;
    w_wake      = 1'b0;
    if (w_busy) begin
      {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
    end else if (r_state == ST_HALT) begin
      if (w_intReq) begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc    = w_expVector;
        w_expTake = 1'b1;
        w_expPc   = r_haltPc;
        w_expCode = EXP_EXT_INT;
        w_wake    = 1'b1;
      end else begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
      end
    end else if (w_memExp || w_intReq) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc    = w_expVector;
      w_expTake = 1'b1;
      w_expCode = w_memExp ? mem_exp_code : EXP_EXT_INT;
    end else if (w_memValid && (mem_ctrl_op == CTRL_EXRT)) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc = w_epc;
      w_exrt = 1'b1;
    end else if (w_memValid && (mem_ctrl_op == CTRL_WSR)) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc = w_nextPc;
      w_wrEn = 1'b1;
    end else if (w_memValid && (mem_ctrl_op == CTRL_HALT)) begin
      {if_flush, id_flush, ex_flush} = 3'b111;
      new_pc      = w_nextPc;
      w_haltEnter = 1'b1;
    end else if (br_taken) begin
      if_flush = 1'b1;
      new_pc   = br_addr;
    end else if (ld_haz) begin
      if_stall = 1'b1;
      id_flush = 1'b1;
    end
  end

  // RUN/HALT state machine; remembers the resume PC while halted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_haltPc <= '0;
    end else if (w_haltEnter) begin
      r_state  <= ST_HALT;
      r_haltPc <= w_nextPc;
    end else if (w_wake) begin
      r_state  <= ST_RUN;
    end
  end

endmodule

// File: tb/tb_yutorina_ctrl_unit.sv
// Directed testbench for yutorina_ctrl_unit. Honours YUTORINA_CYCLE_CNT_EN
// when checking SPR 5.
module tb_yutorina_ctrl_unit;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          if_busy, mem_busy, ld_haz, br_taken, irq, mem_en_;
  logic [AW-1:0] br_addr, mem_pc, new_pc;
  logic [2:0]    mem_exp_code, mem_spr_addr, spr_r_addr;
  logic [1:0]    mem_ctrl_op;
  logic [DW-1:0] mem_out, spr_r_data;
  logic          mode;
  logic          if_stall, id_stall, ex_stall, mem_stall;
  logic          if_flush, id_flush, ex_flush, mem_flush;
  logic [3:0]    stalls, flushes;

  int checks;
  int failures;

  assign stalls  = {if_stall, id_stall, ex_stall, mem_stall};
  assign flushes = {if_flush, id_flush, ex_flush, mem_flush};

  yutorina_ctrl_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_haz(ld_haz), .br_taken(br_taken), .br_addr(br_addr), .irq(irq),
    .mem_en_(mem_en_), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
    .mem_ctrl_op(mem_ctrl_op), .mem_spr_addr(mem_spr_addr), .mem_out(mem_out),
    .spr_r_addr(spr_r_addr), .spr_r_data(spr_r_data), .mode(mode),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_busy = 0; mem_busy = 0; ld_haz = 0; br_taken = 0; br_addr = '0;
    mem_en_ = 1; mem_pc = '0; mem_exp_code = 3'd0; mem_ctrl_op = 2'd0;
    mem_spr_addr = 3'd0; mem_out = '0;
  endtask

  task automatic doWsr(input logic [2:0] a, input logic [DW-1:0] d);
    mem_en_ = 0; mem_ctrl_op = 2'd1; mem_spr_addr = a; mem_out = d; mem_pc = 30'h10;
    tick();
    idle();
  endtask

  task automatic applyReset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle(); irq = 0; spr_r_addr = 3'd0;
    rst = 0;
    #1;
    checks++;
    if (stalls !== 4'b0000 || flushes !== 4'b0000 || new_pc !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs stalls=%b flushes=%b new_pc=%h exp 0/0/0", stalls, flushes, new_pc);
    end
    checks++;
    if (mode !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_mode got=%b exp=0", mode);
    end
    for (int a = 0; a < 8; a++) begin
      spr_r_addr = 3'(a);
      #1;
      checks++;
      if (spr_r_data !== '0) begin
        failures++; $display("[TB] FAIL reset_spr%0d got=%h exp=0", a, spr_r_data);
      end
    end
    tick();
    rst = 1;
  endtask

  task automatic test_busy_branch();
    if_busy = 1; br_taken = 1; br_addr = 30'h1234;
    mem_en_ = 0; mem_exp_code = 3'd2; mem_pc = 30'h55;
    #1;
    checks++;
    if (stalls !== 4'b1111 || flushes !== 4'b0000) begin
      failures++; $display("[TB] FAIL busy_stall stalls=%b flushes=%b exp 1111/0000", stalls, flushes);
    end
    tick();
    if_busy = 0; mem_en_ = 1; mem_exp_code = 3'd0; spr_r_addr = 3'd2;
    #1;
    checks++;
    if (spr_r_data !== '0) begin
      failures++; $display("[TB] FAIL busy_no_commit epc=%h exp=0", spr_r_data);
    end
    checks++;
    if (flushes !== 4'b1000 || stalls !== 4'b0000 || new_pc !== 30'h1234) begin
      failures++;
      $display("[TB] FAIL branch_after_busy flushes=%b stalls=%b new_pc=%h exp 1000/0000/1234", flushes, stalls, new_pc);
    end
    tick();
    idle();
  endtask

  task automatic test_exception_exrt();
    doWsr(3'd3, 32'h40);
    doWsr(3'd0, 32'h3);
    mem_en_ = 0; mem_exp_code = 3'd2; mem_pc = 30'h100;
    #1;
    checks++;
    if (flushes !== 4'b1111 || new_pc !== 30'h40) begin
      failures++; $display("[TB] FAIL undef_redirect flushes=%b new_pc=%h exp 1111/40", flushes, new_pc);
    end
    tick();
    idle();
    spr_r_addr = 3'd2; #1;
    checks++;
    if (spr_r_data !== 32'h100) begin
      failures++; $display("[TB] FAIL undef_epc got=%h exp=100", spr_r_data);
    end
    spr_r_addr = 3'd4; #1;
    checks++;
    if (spr_r_data !== 32'h2) begin
      failures++; $display("[TB] FAIL undef_code got=%h exp=2", spr_r_data);
    end
    spr_r_addr = 3'd0; #1;
    checks++;
    if (spr_r_data !== 32'h0 || mode !== 1'b0) begin
      failures++; $display("[TB] FAIL undef_status got=%h mode=%b exp 0/0", spr_r_data, mode);
    end
    spr_r_addr = 3'd1; #1;
    checks++;
    if (spr_r_data !== 32'h3) begin
      failures++; $display("[TB] FAIL undef_prestatus got=%h exp=3", spr_r_data);
    end
    mem_en_ = 0; mem_ctrl_op = 2'd2; mem_pc = 30'h101;
    #1;
    checks++;
    if (flushes !== 4'b1111 || new_pc !== 30'h100) begin
      failures++; $display("[TB] FAIL exrt_redirect flushes=%b new_pc=%h exp 1111/100", flushes, new_pc);
    end
    tick();
    idle();
    spr_r_addr = 3'd0; #1;
    checks++;
    if (spr_r_data !== 32'h3 || mode !== 1'b1) begin
      failures++; $display("[TB] FAIL exrt_status got=%h mode=%b exp 3/1", spr_r_data, mode);
    end
  endtask

  task automatic test_wsr();
    mem_en_ = 0; mem_ctrl_op = 2'd1; mem_spr_addr = 3'd0; mem_out = 32'h1; mem_pc = 30'h20;
    spr_r_addr = 3'd0;
    #1;
    checks++;
    if (flushes !== 4'b1111 || new_pc !== 30'h21) begin
      failures++; $display("[TB] FAIL wsr_redirect flushes=%b new_pc=%h exp 1111/21", flushes, new_pc);
    end
    checks++;
    if (spr_r_data !== 32'h3) begin
      failures++; $display("[TB] FAIL wsr_no_bypass got=%h exp=3", spr_r_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (mode !== 1'b1 || spr_r_data !== 32'h1) begin
      failures++; $display("[TB] FAIL wsr_status mode=%b spr0=%h exp 1/1", mode, spr_r_data);
    end
    mem_en_ = 0; mem_ctrl_op = 2'd1; mem_spr_addr = 3'd6; mem_out = 32'hFFFF; mem_pc = '1;
    #1;
    checks++;
    if (new_pc !== '0) begin
      failures++; $display("[TB] FAIL wsr_wrap new_pc=%h exp=0", new_pc);
    end
    tick();
    idle();
    spr_r_addr = 3'd6; #1;
    checks++;
    if (spr_r_data !== '0) begin
      failures++; $display("[TB] FAIL wsr_spr6_ignored got=%h exp=0", spr_r_data);
    end
  endtask

  task automatic test_halt_irq();
    doWsr(3'd0, 32'h2);
    mem_en_ = 0; mem_ctrl_op = 2'd3; mem_pc = 30'h30;
    #1;
    checks++;
    if (flushes !== 4'b1110 || stalls !== 4'b0000) begin
      failures++; $display("[TB] FAIL halt_enter flushes=%b stalls=%b exp 1110/0000", flushes, stalls);
    end
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (stalls !== 4'b1111 || flushes !== 4'b0000) begin
        failures++; $display("[TB] FAIL halt_stall cyc=%0d stalls=%b flushes=%b exp 1111/0000", c, stalls, flushes);
      end
      tick();
    end
    irq = 1;
    #1;
    checks++;
    if (flushes !== 4'b1111 || stalls !== 4'b0000 || new_pc !== 30'h40) begin
      failures++;
      $display("[TB] FAIL halt_wake flushes=%b stalls=%b new_pc=%h exp 1111/0000/40", flushes, stalls, new_pc);
    end
    tick();
    irq = 0;
    spr_r_addr = 3'd2; #1;
    checks++;
    if (spr_r_data !== 32'h31 || stalls !== 4'b0000) begin
      failures++; $display("[TB] FAIL wake_epc got=%h stalls=%b exp 31/0000", spr_r_data, stalls);
    end
    spr_r_addr = 3'd4; #1;
    checks++;
    if (spr_r_data !== 32'h1) begin
      failures++; $display("[TB] FAIL wake_code got=%h exp=1", spr_r_data);
    end
  endtask

  task automatic test_halt_no_wake_reset();
    mem_en_ = 0; mem_ctrl_op = 2'd3; mem_pc = 30'h50;
    tick();
    idle();
    irq = 1;
    tick();
    #1;
    checks++;
    if (stalls !== 4'b1111 || flushes !== 4'b0000) begin
      failures++; $display("[TB] FAIL halt_no_wake stalls=%b flushes=%b exp 1111/0000", stalls, flushes);
    end
    rst = 0;
    spr_r_addr = 3'd2;
    #1;
    checks++;
    if (stalls !== 4'b0000 || spr_r_data !== '0) begin
      failures++; $display("[TB] FAIL halt_reset stalls=%b epc=%h exp 0000/0", stalls, spr_r_data);
    end
    irq = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_irq_run();
    doWsr(3'd3, 32'h80);
    doWsr(3'd0, 32'h2);
    irq = 1; mem_pc = 30'h77; br_taken = 1; br_addr = 30'h9;
    #1;
    checks++;
    if (flushes !== 4'b1111 || new_pc !== 30'h80) begin
      failures++; $display("[TB] FAIL irq_run flushes=%b new_pc=%h exp 1111/80", flushes, new_pc);
    end
    tick();
    irq = 0;
    idle();
    spr_r_addr = 3'd2; #1;
    checks++;
    if (spr_r_data !== 32'h77) begin
      failures++; $display("[TB] FAIL irq_epc got=%h exp=77", spr_r_data);
    end
    spr_r_addr = 3'd4; #1;
    checks++;
    if (spr_r_data !== 32'h1) begin
      failures++; $display("[TB] FAIL irq_code got=%h exp=1", spr_r_data);
    end
  endtask

  task automatic test_ldhaz();
    ld_haz = 1;
    #1;
    checks++;
    if (stalls !== 4'b1000 || flushes !== 4'b0100) begin
      failures++; $display("[TB] FAIL ldhaz stalls=%b flushes=%b exp 1000/0100", stalls, flushes);
    end
    br_taken = 1; br_addr = 30'h2A;
    #1;
    checks++;
    if (stalls !== 4'b0000 || flushes !== 4'b1000 || new_pc !== 30'h2A) begin
      failures++;
      $display("[TB] FAIL ldhaz_branch stalls=%b flushes=%b new_pc=%h exp 0000/1000/2a", stalls, flushes, new_pc);
    end
    tick();
    idle();
  endtask

  task automatic test_cycle_cnt();
    logic [DW-1:0] expTen;
    logic [DW-1:0] expLoad;
`ifdef YUTORINA_CYCLE_CNT_EN
    expTen = 32'd10; expLoad = 32'd101;
`else
    expTen = 32'd0;  expLoad = 32'd0;
`endif
    applyReset();
    spr_r_addr = 3'd5;
    repeat (10) tick();
    #1;
    checks++;
    if (spr_r_data !== expTen) begin
      failures++; $display("[TB] FAIL cycle_cnt_10 got=%0d exp=%0d", spr_r_data, expTen);
    end
    doWsr(3'd5, 32'd100);
    tick();
    #1;
    checks++;
    if (spr_r_data !== expLoad) begin
      failures++; $display("[TB] FAIL cycle_cnt_load got=%0d exp=%0d", spr_r_data, expLoad);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    irq = 0;
    rst = 1;
    idle();
    spr_r_addr = 3'd0;
    test_reset();
    test_busy_branch();
    test_exception_exrt();
    test_wsr();
    test_halt_irq();
    test_halt_no_wake_reset();
    applyReset();
    test_irq_run();
    test_ldhaz();
    test_cycle_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
